sram_1r1w_init_ext: RTL and testbench
=====================================

// Module: sram_1r1w_init_ext
// PURPOSE
//  Parametrised behavioural 1R1W SRAM for cache data/tag arrays and scratchpads.
//  Adds configurable mask granularity, 1- or 2-cycle read latency, and a read-during-write policy.
//  After reset, a sweep FSM writes INIT_VAL to every word. Arrays therefore hold defined contents
//  without RANDOMIZE_MEM_INIT.
// PARAMETERS
//  DATA_W    64        word width in bits
//  DEPTH     512       number of words; need not be a power of two
//  ADDR_W    9         address width; must satisfy 2**ADDR_W >= DEPTH
//  MASK_G    8         bits per write-mask lane; DATA_W % MASK_G == 0
//  READ_LAT  1         1: data from the RAM read directly; 2: extra output register
//  RDW_NEW   0         read-during-write, same address: 0 returns old data, 1 returns new (masked merge)
//  INIT_VAL  0         DATA_W-bit value written to every word by the init sweep
// PORTS
//  clock       in   1                 single clock for both ports
//  reset       in   1                 asynchronous, active-high
//  W_en        in   1                 write request
//  W_addr      in   ADDR_W            write address
//  W_data      in   DATA_W            write data
//  W_mask      in   DATA_W/MASK_G     lane enables; bit i covers data[i*MASK_G +: MASK_G]
//  R_en        in   1                 read request
//  R_addr      in   ADDR_W            read address
//  R_data      out  DATA_W            read data; held between reads
//  R_valid     out  1                 R_data is valid for a read accepted READ_LAT cycles earlier
//  ready       out  1                 requests are accepted; equals !init_busy
//  init_busy   out  1                 init sweep in progress
// BEHAVIOUR
//  Reset values (while reset=1): R_valid=0, R_data=0, init_busy=1, ready=0, sweep pointer=0,
//   and every pipeline valid bit is cleared.
//  FSM state INIT:
//   - Entered on reset.
//   - Each clock, writes INIT_VAL at the sweep pointer and increments the pointer.
//   - The write to DEPTH-1 completes in the last INIT cycle. Next cycle: state RUN, init_busy=0, ready=1.
//   - The sweep therefore lasts exactly DEPTH cycles after reset deasserts.
//   - During INIT, W_en and R_en are ignored: no array write and no R_valid.
//  FSM state RUN:
//   - Stays in RUN until reset.
//   - An asserted reset in any state, including mid-sweep, forces INIT with the pointer at 0.
//  Write (RUN, W_en=1):
//   - At the clock edge, only lanes with W_mask[i]=1 are updated. W_mask=0 writes nothing.
//   - W_addr >= DEPTH: the write is dropped.
//  Read (RUN, R_en=1):
//   - Address is sampled at edge T.
//   - READ_LAT=1: R_data and R_valid=1 appear after edge T.
//   - READ_LAT=2: they appear after edge T+1.
//   - R_valid is a one-cycle pulse per accepted read. Back-to-back reads give a continuous valid.
//   - R_addr >= DEPTH: R_valid still pulses and R_data=0.
//   - With no read, R_data holds its last value and R_valid=0.
//  Read and write to the same address at the same edge:
//   - RDW_NEW=0: read returns the pre-write word.
//   - RDW_NEW=1: read returns (old & ~lanemask) | (W_data & lanemask).
//   - Different addresses: independent, no interaction.
//  A write at edge T to address A is visible to a read sampled at edge T+1 or later, independent of RDW_NEW.
//  Widths: R_data is exactly DATA_W bits; no truncation or padding of the stored word.
// TESTING
//  Sweep length (DEPTH=512): release reset, count cycles -> init_busy high exactly 512 cycles;
//   read of 0 and 511 returns INIT_VAL.
//  Reset abort: assert reset at sweep cycle 100 for 2 cycles, release -> init_busy high 512 more cycles;
//   a W_en issued during init does not alter the array.
//  Byte mask (DATA_W=64, MASK_G=8):
//   - Write 64'hFFFF_FFFF_FFFF_FFFF mask 8'hFF to addr 5.
//   - Then write 64'h0 mask 8'h0F to addr 5.
//   - Read addr 5 -> 64'hFFFF_FFFF_0000_0000.
//  Latency: READ_LAT=2, reads to addr 1,2,3 on consecutive cycles ->
//   R_valid high on cycles +2,+3,+4 with matching data; R_data holds after the last read.
//  RDW policy, addr 7 holding 64'hAAAA..., same-cycle write 64'h5555... mask 8'hF0 plus read:
//   - RDW_NEW=0 -> 64'hAAAA...AAAA.
//   - RDW_NEW=1 -> 64'h5555_5555_AAAA_AAAA.
//  Bounds: DEPTH=500 -> write to addr 510 is dropped; read of addr 510 gives R_valid=1, R_data=0.

Source files
------------

// File: rtl/sram_1r1w_init_ext.sv
// sram_1r1w_init_ext
// Behavioural 1R1W SRAM with lane-masked writes, 1- or 2-cycle read latency,
// a selectable read-during-write policy, and a post-reset sweep that writes
// INIT_VAL to every word before any request is accepted.

module sram_1r1w_init_ext #(
    parameter int unsigned       DATA_W   = 64,
    parameter int unsigned       DEPTH    = 512,
    parameter int unsigned       ADDR_W   = 9,
    parameter int unsigned       MASK_G   = 8,
    parameter int unsigned       READ_LAT = 1,
    parameter bit                RDW_NEW  = 1'b0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     W_en,
    input  logic [ADDR_W-1:0]        W_addr,
    input  logic [DATA_W-1:0]        W_data,
    input  logic [DATA_W/MASK_G-1:0] W_mask,
    input  logic                     R_en,
    input  logic [ADDR_W-1:0]        R_addr,
    output logic [DATA_W-1:0]        R_data,
    output logic                     R_valid,
    output logic                     ready,
    output logic                     init_busy
);

    localparam int unsigned LANES = DATA_W / MASK_G;

    // Depth widened by one bit so addresses up to 2**ADDR_W-1 compare cleanly.
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   sweep_ptr;
    logic [ADDR_W-1:0]   sweep_ptr_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                run;
    logic                w_in_range;
    logic                r_in_range;
    logic                w_fire;
    logic                r_fire;
    logic [DATA_W-1:0]   w_bits;
    logic [DATA_W-1:0]   rd_word;

    logic                s1_valid;
    logic [DATA_W-1:0]   s1_data;

    // ------------------------------------------------------------------
    // Init sweep FSM
    // ------------------------------------------------------------------

    // State and sweep pointer registers; any reset restarts the sweep at word 0.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of process ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else begin
            state     <= state_nxt;
            sweep_ptr <= sweep_ptr_nxt;
        end
    end

    // Next state: one word per cycle, leave INIT after the last word is written.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        sweep_ptr_nxt = sweep_ptr;
        case (state)
            ST_INIT: begin
                sweep_ptr_nxt = sweep_ptr + ADDR_W'(1);
                if (sweep_ptr == LAST_PTR) begin
                    state_nxt     = ST_RUN;
                    sweep_ptr_nxt = '0;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    assign init_busy = (state == ST_INIT);
    assign ready     = ~init_busy;
    assign run       = ready;

    // ------------------------------------------------------------------
    // Request qualification
    // ------------------------------------------------------------------

    assign w_in_range = ({1'b0, W_addr} < DEPTH_C);
    assign r_in_range = ({1'b0, R_addr} < DEPTH_C);
    assign w_fire     = run & W_en & w_in_range;
    assign r_fire     = run & R_en;

    // Expand per-lane write enables into a per-bit mask.
    always_comb begin
        w_bits = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_bits[i*MASK_G +: MASK_G] = {MASK_G{W_mask[i]}};
        end
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------

    // Array write: init sweep has priority, otherwise a lane-masked merge.
    // NOTE: the array has no reset branch; its defined contents come from the
    // sweep, which keeps it mappable onto a real SRAM macro.
    always_ff @(posedge clock) begin
        if (init_busy) begin
            mem[sweep_ptr] <= INIT_VAL;
        end else if (w_fire) begin
            mem[W_addr] <= (mem[W_addr] & ~w_bits) | (W_data & w_bits);
        end
    end

    // Read word: zero when out of range, optionally forwarding a same-address write.
    always_comb begin
        rd_word = '0;
        if (r_in_range) begin
            rd_word = mem[R_addr];
            if (RDW_NEW && w_fire && (W_addr == R_addr)) begin
                rd_word = (rd_word & ~w_bits) | (W_data & w_bits);
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------

    // First read stage: capture the word on an accepted read, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= r_fire;
            if (r_fire) begin
                s1_data <= rd_word;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              s2_valid;
            logic [DATA_W-1:0] s2_data;

            // Optional output register: one more cycle, data held between reads.
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign R_valid = s2_valid;
            assign R_data  = s2_data;
        end else begin : g_lat1
            assign R_valid = s1_valid;
            assign R_data  = s1_data;
        end
    endgenerate

endmodule

// File: tb/tb_sram_1r1w_init_ext.sv
// tb_sram_1r1w_init_ext
// Directed bench with two instances: A (DEPTH 512, 1-cycle read, old-data RDW)
// and B (DEPTH 500, 2-cycle read, new-data RDW). Expected values are hand-computed.

module tb_sram_1r1w_init_ext;

    localparam logic [63:0] INIT_A = 64'hC3C3_0F0F_A5A5_1234;
    localparam logic [63:0] INIT_B = 64'h1111_2222_3333_4444;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] PAT_A  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] PAT_5  = 64'h5555_5555_5555_5555;
    localparam logic [63:0] MERGE  = 64'h5555_5555_AAAA_AAAA;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A signals
    logic        rst_a, w_en_a, r_en_a, r_valid_a, ready_a, busy_a;
    logic [8:0]  w_addr_a, r_addr_a;
    logic [63:0] w_data_a, r_data_a;
    logic [7:0]  w_mask_a;

    // Instance B signals
    logic        rst_b, w_en_b, r_en_b, r_valid_b, ready_b, busy_b;
    logic [8:0]  w_addr_b, r_addr_b;
    logic [63:0] w_data_b, r_data_b;
    logic [7:0]  w_mask_b;

    sram_1r1w_init_ext #(
        .DATA_W(64), .DEPTH(512), .ADDR_W(9), .MASK_G(8),
        .READ_LAT(1), .RDW_NEW(1'b0), .INIT_VAL(INIT_A)
    ) u_a (
        .clock(clock), .reset(rst_a),
        .W_en(w_en_a), .W_addr(w_addr_a), .W_data(w_data_a), .W_mask(w_mask_a),
        .R_en(r_en_a), .R_addr(r_addr_a), .R_data(r_data_a), .R_valid(r_valid_a),
        .ready(ready_a), .init_busy(busy_a)
    );

    sram_1r1w_init_ext #(
        .DATA_W(64), .DEPTH(500), .ADDR_W(9), .MASK_G(8),
        .READ_LAT(2), .RDW_NEW(1'b1), .INIT_VAL(INIT_B)
    ) u_b (
        .clock(clock), .reset(rst_b),
        .W_en(w_en_b), .W_addr(w_addr_b), .W_data(w_data_b), .W_mask(w_mask_b),
        .R_en(r_en_b), .R_addr(r_addr_b), .R_data(r_data_b), .R_valid(r_valid_b),
        .ready(ready_b), .init_busy(busy_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr_a(input logic [8:0] addr, input logic [63:0] data, input logic [7:0] mask);
        w_en_a = 1'b1; w_addr_a = addr; w_data_a = data; w_mask_a = mask;
        tick();
        w_en_a = 1'b0;
    endtask

    task automatic wr_b(input logic [8:0] addr, input logic [63:0] data, input logic [7:0] mask);
        w_en_b = 1'b1; w_addr_b = addr; w_data_b = data; w_mask_b = mask;
        tick();
        w_en_b = 1'b0;
    endtask

    task automatic rd_a(input logic [8:0] addr, input logic [63:0] exp, input string tag);
        r_en_a = 1'b1; r_addr_a = addr;
        tick();
        r_en_a = 1'b0;
        check({tag, "_valid"}, {63'd0, r_valid_a}, 64'd1);
        check(tag, r_data_a, exp);
    endtask

    task automatic rd_b(input logic [8:0] addr, input logic [63:0] exp, input string tag);
        r_en_b = 1'b1; r_addr_b = addr;
        tick();
        r_en_b = 1'b0;
        check({tag, "_early"}, {63'd0, r_valid_b}, 64'd0);
        tick();
        check({tag, "_valid"}, {63'd0, r_valid_b}, 64'd1);
        check(tag, r_data_b, exp);
    endtask

    int   cnt_a, cnt_b, guard;
    logic done_a, done_b, saw_valid;

    initial begin
        rst_a = 1'b1; w_en_a = 1'b0; r_en_a = 1'b0;
        w_addr_a = '0; r_addr_a = '0; w_data_a = '0; w_mask_a = '0;
        rst_b = 1'b1; w_en_b = 1'b0; r_en_b = 1'b0;
        w_addr_b = '0; r_addr_b = '0; w_data_b = '0; w_mask_b = '0;
        repeat (3) tick();

        // Reset state
        check("rst_valid", {63'd0, r_valid_a}, 64'd0);
        check("rst_data",  r_data_a, 64'd0);
        check("rst_busy",  {63'd0, busy_a}, 64'd1);
        check("rst_ready", {63'd0, ready_a}, 64'd0);
        check("rst_busy_b", {63'd0, busy_b}, 64'd1);

        // First sweep on A with requests that must be ignored, aborted at cycle 100
        rst_a = 1'b0;
        w_en_a = 1'b1; w_addr_a = 9'd3; w_data_a = 64'd0; w_mask_a = 8'hFF;
        r_en_a = 1'b1; r_addr_a = 9'd3;
        saw_valid = 1'b0;
        repeat (100) begin
            tick();
            if (r_valid_a) saw_valid = 1'b1;
        end
        check("busy_mid", {63'd0, busy_a}, 64'd1);
        rst_a = 1'b1;
        tick();
        tick();

        // Full sweeps: A restarts, B starts; count cycles until init_busy drops
        rst_a = 1'b0; rst_b = 1'b0;
        cnt_a = 0; cnt_b = 0; guard = 0; done_a = 1'b0; done_b = 1'b0;
        while (!(done_a && done_b) && guard < 2000) begin
            tick();
            guard++;
            if (!done_a) begin
                cnt_a++;
                if (r_valid_a) saw_valid = 1'b1;
                if (!busy_a) begin
                    done_a = 1'b1; w_en_a = 1'b0; r_en_a = 1'b0;
                end
            end
            if (!done_b) begin
                cnt_b++;
                if (!busy_b) done_b = 1'b1;
            end
        end
        check("sweep_len_a", 64'(cnt_a), 64'd512);
        check("sweep_len_b", 64'(cnt_b), 64'd500);
        check("init_no_rvalid", {63'd0, saw_valid}, 64'd0);
        check("ready_a", {63'd0, ready_a}, 64'd1);

        // Sweep contents, including the word targeted by the ignored init write
        rd_a(9'd0,   INIT_A, "a_init0");
        rd_a(9'd511, INIT_A, "a_init511");
        rd_a(9'd100, INIT_A, "a_init100");
        rd_a(9'd3,   INIT_A, "a_init_wr_ignored");
        tick();
        check("a_idle_valid", {63'd0, r_valid_a}, 64'd0);
        check("a_idle_hold",  r_data_a, INIT_A);

        // Lane masks
        wr_a(9'd5, ONES, 8'hFF);
        wr_a(9'd5, 64'd0, 8'h0F);
        rd_a(9'd5, 64'hFFFF_FFFF_0000_0000, "a_bytemask");
        wr_a(9'd5, 64'd0, 8'h00);
        rd_a(9'd5, 64'hFFFF_FFFF_0000_0000, "a_mask_zero");

        // Same-address read during write, old-data policy
        wr_a(9'd7, PAT_A, 8'hFF);
        w_en_a = 1'b1; w_addr_a = 9'd7; w_data_a = PAT_5; w_mask_a = 8'hF0;
        r_en_a = 1'b1; r_addr_a = 9'd7;
        tick();
        w_en_a = 1'b0; r_en_a = 1'b0;
        check("a_rdw_old", r_data_a, PAT_A);
        rd_a(9'd7, MERGE, "a_after_write");

        // Different addresses in the same cycle do not interact
        w_en_a = 1'b1; w_addr_a = 9'd8; w_data_a = PAT_5; w_mask_a = 8'hFF;
        r_en_a = 1'b1; r_addr_a = 9'd9;
        tick();
        w_en_a = 1'b0; r_en_a = 1'b0;
        check("a_diff_addr", r_data_a, INIT_A);
        rd_a(9'd8, PAT_5, "a_diff_written");

        // Instance B: contents, 2-cycle latency
        rd_b(9'd0,   INIT_B, "b_init0");
        rd_b(9'd499, INIT_B, "b_init499");

        // Same-address read during write, new-data policy
        wr_b(9'd7, PAT_A, 8'hFF);
        w_en_b = 1'b1; w_addr_b = 9'd7; w_data_b = PAT_5; w_mask_b = 8'hF0;
        r_en_b = 1'b1; r_addr_b = 9'd7;
        tick();
        w_en_b = 1'b0; r_en_b = 1'b0;
        tick();
        check("b_rdw_new", r_data_b, MERGE);

        // Back-to-back reads of 1,2,3
        wr_b(9'd1, 64'h0000_0000_0000_0101, 8'hFF);
        wr_b(9'd2, 64'h0000_0000_0000_0202, 8'hFF);
        wr_b(9'd3, 64'h0000_0000_0000_0303, 8'hFF);
        r_en_b = 1'b1; r_addr_b = 9'd1;
        tick();
        check("b_lat_c1_valid", {63'd0, r_valid_b}, 64'd0);
        r_addr_b = 9'd2;
        tick();
        check("b_lat_c2_valid", {63'd0, r_valid_b}, 64'd1);
        check("b_lat_c2_data",  r_data_b, 64'h0101);
        r_addr_b = 9'd3;
        tick();
        r_en_b = 1'b0;
        check("b_lat_c3_valid", {63'd0, r_valid_b}, 64'd1);
        check("b_lat_c3_data",  r_data_b, 64'h0202);
        tick();
        check("b_lat_c4_valid", {63'd0, r_valid_b}, 64'd1);
        check("b_lat_c4_data",  r_data_b, 64'h0303);
        tick();
        check("b_lat_c5_valid", {63'd0, r_valid_b}, 64'd0);
        check("b_lat_c5_hold",  r_data_b, 64'h0303);

        // Out-of-range address: write dropped, read pulses valid with zero data
        wr_b(9'd510, 64'h0123_4567_89AB_CDEF, 8'hFF);
        rd_b(9'd510, 64'd0, "b_oob_read");
        rd_b(9'd499, INIT_B, "b_last_intact");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
